// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO: the head word is always presented on dout
// while non-empty, and rd_en acknowledges (pops) it.
module fallthrough_small_fifo #(
    parameter int WIDTH               = 72,
    parameter int MAX_DEPTH_BITS      = 3,
    parameter int PROG_FULL_THRESHOLD = (1 << MAX_DEPTH_BITS) - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             nearly_full,
    output logic             prog_full,
    output logic             empty
);

    localparam int DEPTH = 1 << MAX_DEPTH_BITS;
    localparam int CNT_W = MAX_DEPTH_BITS + 1;

    localparam logic [CNT_W-1:0] DEPTH_CNT       = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] NEARLY_FULL_CNT = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] PROG_FULL_CNT   = CNT_W'(PROG_FULL_THRESHOLD);

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [CNT_W-1:0]          depth;

    logic wr_accept;
    logic rd_accept;

    // A write while full is dropped even when a pop happens in the same cycle.
    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;

    // NOTE: the storage array has no reset; its contents are only observable
    // through rd_ptr, and the occupancy guards every stale word.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            depth  <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_accept, rd_accept})
                2'b10:   depth <= depth + 1'b1;
                2'b01:   depth <= depth - 1'b1;
                default: depth <= depth;
            endcase
        end
    end

    assign dout        = mem[rd_ptr];
    assign empty       = (depth == '0);
    assign full        = (depth == DEPTH_CNT);
    assign nearly_full = (depth >= NEARLY_FULL_CNT);
    assign prog_full   = (depth >= PROG_FULL_CNT);

endmodule

// File: tb/tb_fallthrough_small_fifo.sv
// Directed self-checking bench for fallthrough_small_fifo (8-bit x 8 instance
// plus a 417-bit x 64 instance for bit-exact data transfer).
module tb_fallthrough_small_fifo;

    localparam int W  = 8;
    localparam int WW = 417;

    logic         clk;
    logic         reset;
    logic [W-1:0] din;
    logic         wr_en;
    logic         rd_en;
    logic [W-1:0] dout;
    logic         full;
    logic         nearly_full;
    logic         prog_full;
    logic         empty;

    logic [WW-1:0] w_din;
    logic          w_wr_en;
    logic          w_rd_en;
    logic [WW-1:0] w_dout;
    logic          w_full;
    logic          w_nearly_full;
    logic          w_prog_full;
    logic          w_empty;

    int n_checks = 0;
    int n_fail   = 0;

    fallthrough_small_fifo #(
        .WIDTH(W),
        .MAX_DEPTH_BITS(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .din(din),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .dout(dout),
        .full(full),
        .nearly_full(nearly_full),
        .prog_full(prog_full),
        .empty(empty)
    );

    fallthrough_small_fifo #(
        .WIDTH(WW),
        .MAX_DEPTH_BITS(6)
    ) dut_wide (
        .clk(clk),
        .reset(reset),
        .din(w_din),
        .wr_en(w_wr_en),
        .rd_en(w_rd_en),
        .dout(w_dout),
        .full(w_full),
        .nearly_full(w_nearly_full),
        .prog_full(w_prog_full),
        .empty(w_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [447:0] obs, input logic [447:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d);
        din   = d;
        wr_en = 1'b1;
        rd_en = 1'b0;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pop();
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    logic [WW-1:0] pat_a;
    logic [WW-1:0] pat_b;
    logic [W-1:0]  exp_head;

    initial begin
        reset   = 1'b0;
        din     = '0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        w_din   = '0;
        w_wr_en = 1'b0;
        w_rd_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_nearly_full", nearly_full, 1'b0);
        check("rst_prog_full", prog_full, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_empty", empty, 1'b1);

        // Write-then-read with 1-cycle visibility.
        push(8'h11);
        check("wr1_empty", empty, 1'b0);
        check("wr1_dout", dout, 8'h11);
        push(8'h22);
        push(8'h33);
        check("wr3_dout_head", dout, 8'h11);
        pop();
        check("pop1_dout", dout, 8'h22);
        pop();
        check("pop2_dout", dout, 8'h33);
        pop();
        check("pop3_empty", empty, 1'b1);

        // Fill to DEPTH, drop the overflow write, drain in order.
        for (int i = 0; i < 8; i++) begin
            push(W'(i));
            if (i == 5) check("fill6_nearly_full", nearly_full, 1'b0);
            if (i == 6) begin
                check("fill7_nearly_full", nearly_full, 1'b1);
                check("fill7_full", full, 1'b0);
                check("fill7_prog_full", prog_full, 1'b1);
            end
        end
        check("fill8_full", full, 1'b1);
        check("fill8_prog_full", prog_full, 1'b1);
        push(8'hAA);
        check("ovf_full", full, 1'b1);
        check("ovf_dout", dout, 8'h00);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain_%0d", i), dout, W'(i));
            pop();
        end
        check("drain_empty", empty, 1'b1);

        // Simultaneous write+pop at occupancy 4, across pointer wrap.
        for (int i = 0; i < 4; i++) push(8'h40 + W'(i));
        wr_en = 1'b1;
        rd_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            din      = 8'h50 + W'(k);
            exp_head = (k < 4) ? 8'h40 + W'(k) : 8'h50 + W'(k - 4);
            check($sformatf("sim_dout_%0d", k), dout, exp_head);
            check($sformatf("sim_full_%0d", k), full, 1'b0);
            check($sformatf("sim_empty_%0d", k), empty, 1'b0);
            tick();
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("sim_drain_%0d", i), dout, 8'h60 + W'(i));
            pop();
        end
        check("sim_drain_empty", empty, 1'b0 == 1'b0 ? 1'b1 : 1'b0);

        // Empty corner cases.
        pop();
        check("rd_empty_empty", empty, 1'b1);
        check("rd_empty_full", full, 1'b0);
        din   = 8'h5A;
        wr_en = 1'b1;
        rd_en = 1'b1;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("wr_rd_empty_empty", empty, 1'b0);
        check("wr_rd_empty_dout", dout, 8'h5A);
        pop();
        check("wr_rd_empty_drain", empty, 1'b1);

        // Asynchronous reset between edges discards queued words.
        for (int i = 1; i <= 5; i++) push(W'(i));
        check("pre_arst_empty", empty, 1'b0);
        #3 reset = 1'b1;
        #1;
        check("arst_empty", empty, 1'b1);
        check("arst_full", full, 1'b0);
        check("arst_nearly_full", nearly_full, 1'b0);
        din   = 8'hCC;
        wr_en = 1'b1;
        tick();
        check("arst_wr_ignored", empty, 1'b1);
        reset = 1'b0;
        wr_en = 1'b0;
        tick();
        check("arst_release_empty", empty, 1'b1);
        push(8'h77);
        check("arst_after_dout", dout, 8'h77);
        pop();
        check("arst_after_empty", empty, 1'b1);

        // Full with simultaneous write+pop: write dropped, pop happens.
        for (int i = 0; i < 8; i++) push(8'h80 + W'(i));
        check("fr_full", full, 1'b1);
        din   = 8'hEE;
        wr_en = 1'b1;
        rd_en = 1'b1;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("fr_full_after", full, 1'b0);
        check("fr_nearly_full_after", nearly_full, 1'b1);
        for (int i = 1; i < 8; i++) begin
            check($sformatf("fr_drain_%0d", i), dout, 8'h80 + W'(i));
            pop();
        end
        check("fr_drain_empty", empty, 1'b1);

        // Bit-exact transfer on the 417-bit instance.
        for (int i = 0; i < WW; i++) begin
            pat_a[i] = ((i % 3) == 0) ^ ((i % 7) == 1);
        end
        pat_b = ~pat_a;
        check("wide_empty", w_empty, 1'b1);
        w_din   = pat_a;
        w_wr_en = 1'b1;
        tick();
        w_din = pat_b;
        tick();
        w_wr_en = 1'b0;
        check("wide_dout_a", w_dout, pat_a);
        w_rd_en = 1'b1;
        tick();
        check("wide_dout_b", w_dout, pat_b);
        tick();
        w_rd_en = 1'b0;
        check("wide_drain_empty", w_empty, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
